// File: rtl/vegeta_seq_ctrl_fp6_pkg.sv
// Shared types and constants for the FP6 VEGETA sequencer.
package vTPU_pkg_fp6;

    // Default array geometry; modules take these as parameter defaults.
    localparam int X_SCALED_DEF  = 4;
    localparam int Y_SCALED_DEF  = 4;
    localparam int ADDER_LAT_DEF = 2;
    localparam int CNT_W_DEF     = 12;

    // Issue-to-last-column latency span of the array plus adder trees.
    localparam int PIPE_LAT = X_SCALED_DEF + Y_SCALED_DEF + ADDER_LAT_DEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WLOAD  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } seq_state_e;

    localparam logic [1:0] GEMM_DENSE = 2'd0;
    localparam logic [1:0] GEMM_2_4   = 2'd1;
    localparam logic [1:0] GEMM_1_4   = 2'd2;
    localparam logic [1:0] GEMM_RSVD  = 2'd3;

    // Only the reserved encoding is rejected.
    function automatic logic gemm_mode_legal(input logic [1:0] gm);
        return gm != GEMM_RSVD;
    endfunction

endpackage

// File: rtl/vegeta_seq_ctrl_fp6_valid_delay.sv
// Valid-bit shift register with a tap per delay: o_taps[k] is i_in delayed k cycles.
module vegeta_valid_delay #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in,
    output logic [DEPTH-1:0] o_taps
);

    logic [DEPTH-1:1] r_sr;

    // Shift the valid bit one stage per cycle; reset drops everything in flight.
    // NOTE: this chain carries valid bits, so it is reset (unlike a data pipe),
    // and its stages use non-blocking assignments so each reads last cycle's neighbour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else begin
            r_sr[1] <= i_in;
            for (int k = 2; k < DEPTH; k++) begin
                r_sr[k] <= r_sr[k-1];
            end
        end
    end

    assign o_taps = {r_sr, i_in};

endmodule

// File: rtl/vegeta_seq_ctrl_fp6.sv
// Job sequencer for the FP6 VEGETA systolic array: weight load with shadow
// buffer ping-pong, skewed activation issue, drain and column-valid strobes.
module vegeta_seq_ctrl_fp6
    import vTPU_pkg_fp6::*;
#(
    parameter int X_SCALED  = X_SCALED_DEF,
    parameter int Y_SCALED  = Y_SCALED_DEF,
    parameter int ADDER_LAT = ADDER_LAT_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [1:0]          cmd_gemm_mode,
    input  logic [CNT_W-1:0]    cmd_num_wtiles,
    input  logic [CNT_W-1:0]    cmd_num_rows,
    input  logic [7:0]          cmd_input_scale,
    input  logic [7:0]          cmd_weight_scale,
    input  logic                act_avail,
    output logic                w_rd_en,
    output logic                weight_transferring_in,
    output logic                i_wb,
    output logic [1:0]          mode,
    output logic [1:0]          gemm_mode,
    output logic [7:0]          input_scale,
    output logic [7:0]          weight_scale,
    output logic [X_SCALED-1:0] act_row_en,
    output logic [Y_SCALED-1:0] col_valid,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int PIPE_D = X_SCALED + Y_SCALED + ADDER_LAT;
    localparam int WL_W   = (X_SCALED > 1) ? $clog2(X_SCALED) : 1;

    seq_state_e       r_state, w_state_nxt;
    logic [WL_W-1:0]  r_wl_cnt;
    logic [CNT_W-1:0] r_row_cnt, r_tile_cnt, r_num_rows, r_num_wtiles;
    logic [1:0]       r_mode, r_gemm_mode;
    logic [7:0]       r_input_scale, r_weight_scale;
    logic             r_wb, r_wt, r_err, r_err_done;
    logic             w_accept, w_illegal, w_issue, w_last_row, w_last_wl;
    logic             w_pipe_empty, w_more_tiles, w_drain_done, w_next_tile;
    logic [PIPE_D-1:0] w_col_taps;

    assign w_accept     = cmd_valid && cmd_ready;
    assign w_illegal    = (cmd_num_wtiles == '0) || (cmd_num_rows == '0) ||
                          !gemm_mode_legal(cmd_gemm_mode);
    assign w_issue      = (r_state == STREAM) && act_avail;
    assign w_last_row   = (r_row_cnt == r_num_rows - CNT_W'(1));
    assign w_last_wl    = (r_wl_cnt == WL_W'(X_SCALED - 1));
    assign w_pipe_empty = ~|w_col_taps;
    assign w_more_tiles = ({1'b0, r_tile_cnt} + (CNT_W+1)'(1)) < {1'b0, r_num_wtiles};
    assign w_drain_done = (r_state == DRAIN) && w_pipe_empty && !w_more_tiles;
    assign w_next_tile  = (r_state == DRAIN) && w_pipe_empty && w_more_tiles;

    // Next-state decode for the job FSM.
    // NOTE: defaulting w_state_nxt first keeps this block free of inferred latches.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_illegal) w_state_nxt = WLOAD;
            WLOAD:   if (w_last_wl) w_state_nxt = STREAM;
            STREAM:  if (w_issue && w_last_row) w_state_nxt = DRAIN;
            DRAIN:   if (w_pipe_empty) w_state_nxt = w_more_tiles ? WLOAD : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Descriptor capture on acceptance; err is sticky until the next accepted command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode         <= '0;
            r_gemm_mode    <= '0;
            r_input_scale  <= '0;
            r_weight_scale <= '0;
            r_num_rows     <= '0;
            r_num_wtiles   <= '0;
            r_err          <= 1'b0;
            r_err_done     <= 1'b0;
        end else begin
            r_err_done <= w_accept && w_illegal;
            if (w_accept) begin
                r_mode         <= cmd_mode;
                r_gemm_mode    <= cmd_gemm_mode;
                r_input_scale  <= cmd_input_scale;
                r_weight_scale <= cmd_weight_scale;
                r_num_rows     <= cmd_num_rows;
                r_num_wtiles   <= cmd_num_wtiles;
                r_err          <= w_illegal;
            end
        end
    end

    // Weight-load, row and tile counters plus the shadow buffer select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wl_cnt   <= '0;
            r_row_cnt  <= '0;
            r_tile_cnt <= '0;
            r_wb       <= 1'b0;
        end else if (w_accept) begin
            r_wl_cnt   <= '0;
            r_row_cnt  <= '0;
            r_tile_cnt <= '0;
            r_wb       <= 1'b0;
        end else begin
            if (r_state == WLOAD) r_wl_cnt <= w_last_wl ? '0 : r_wl_cnt + WL_W'(1);
            if (w_issue)          r_row_cnt <= w_last_row ? '0 : r_row_cnt + CNT_W'(1);
            if (w_next_tile) begin
                r_wb       <= ~r_wb;
                r_tile_cnt <= r_tile_cnt + CNT_W'(1);
            end
        end
    end

    // Weight data arrives one cycle after the SRAM read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wt <= 1'b0;
        else     r_wt <= w_rd_en;
    end

    vegeta_valid_delay #(.DEPTH(X_SCALED)) u_row_skew (
        .clk    (clk),
        .rst    (rst),
        .i_in   (w_issue),
        .o_taps (act_row_en)
    );

    vegeta_valid_delay #(.DEPTH(PIPE_D)) u_col_delay (
        .clk    (clk),
        .rst    (rst),
        .i_in   (w_issue),
        .o_taps (w_col_taps)
    );

    // Column c sees an issue X_SCALED+ADDER_LAT+c cycles later.
    assign col_valid              = w_col_taps[PIPE_D-1 -: Y_SCALED];
    assign cmd_ready              = (r_state == IDLE);
    assign busy                   = (r_state != IDLE);
    assign w_rd_en                = (r_state == WLOAD);
    assign weight_transferring_in = r_wt;
    assign i_wb                   = r_wb;
    assign mode                   = r_mode;
    assign gemm_mode              = r_gemm_mode;
    assign input_scale            = r_input_scale;
    assign weight_scale           = r_weight_scale;
    assign err                    = r_err;
    assign done                   = r_err_done | w_drain_done;

endmodule
